// File: rtl/point_add_arbiter.sv
// rtl/point_add_arbiter.sv - round-robin sequencer sharing one point_add unit
// Point type is shared with the requesters and the adder; all-zero encodes the point at infinity.
package point_add_pkg;
  localparam int COORD_W = 16;
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } curve_point_t;
  localparam curve_point_t inf_point = '0;
endpackage

module point_add_arbiter
  import point_add_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 Reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  curve_point_t         req_P [NUM_REQ],
  input  curve_point_t         req_Q [NUM_REQ],
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output curve_point_t         rsp_R,
  output logic                 add_reset,
  output curve_point_t         add_P,
  output curve_point_t         add_Q,
  input  curve_point_t         add_R,
  input  logic                 add_done,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] ops_count
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESPOND} state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic [IW-1:0]        r_idx, w_idx_nxt;
  logic [IW-1:0]        r_rr_ptr, w_rr_ptr_nxt;
  curve_point_t         r_p, r_q, r_rsp_r;
  curve_point_t         w_p_nxt, w_q_nxt, w_rsp_r_nxt;
  logic [CNT_WIDTH-1:0] r_ops, w_ops_nxt;

  logic [NUM_REQ-1:0]   w_elig;
  logic [IW-1:0]        w_start, w_win, w_idx_inc;
  logic                 w_found;
  curve_point_t         w_win_p, w_win_q;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // While responding, the served index is masked and the search starts just past it,
  // which is exactly where rr_ptr lands once the response completes.
  assign w_idx_inc = wrap_inc(r_idx, 1);
  assign w_elig    = (r_state == S_RESPOND) ? (req & ~r_gnt) : req;
  assign w_start   = (r_state == S_RESPOND) ? w_idx_inc : r_rr_ptr;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_elig[wrap_inc(w_start, k)]) begin
        w_found = 1'b1;
        w_win   = wrap_inc(w_start, k);
      end
    end
  end

  assign w_win_p = req_P[w_win];
  assign w_win_q = req_Q[w_win];

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_idx_nxt    = r_idx;
    w_rr_ptr_nxt = r_rr_ptr;
    w_p_nxt      = r_p;
    w_q_nxt      = r_q;
    w_rsp_r_nxt  = r_rsp_r;
    w_ops_nxt    = r_ops;
    case (r_state)
      S_IDLE, S_RESPOND: begin
        if (r_state == S_RESPOND) begin
          w_ops_nxt    = r_ops + CNT_WIDTH'(1);
          w_rr_ptr_nxt = w_idx_inc;
          w_gnt_nxt    = '0;
        end
        if (w_found) begin
          w_gnt_nxt = NUM_REQ'(1) << w_win;
          w_idx_nxt = w_win;
          w_p_nxt   = w_win_p;
          w_q_nxt   = w_win_q;
          // Adding infinity is the identity, so the adder is skipped entirely.
          if (w_win_p == inf_point || w_win_q == inf_point) begin
            w_rsp_r_nxt = (w_win_p == inf_point) ? w_win_q : w_win_p;
            w_state_nxt = S_RESPOND;
          end else begin
            w_state_nxt = S_LAUNCH;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (add_done) begin
          w_rsp_r_nxt = add_R;
          w_state_nxt = S_RESPOND;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_idx    <= '0;
      r_rr_ptr <= '0;
      r_p      <= inf_point;
      r_q      <= inf_point;
      r_rsp_r  <= inf_point;
      r_ops    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_idx    <= w_idx_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_p      <= w_p_nxt;
      r_q      <= w_q_nxt;
      r_rsp_r  <= w_rsp_r_nxt;
      r_ops    <= w_ops_nxt;
    end
  end

  // The adder is held in reset everywhere except WAIT, so LAUNCH is its single start cycle.
  assign gnt       = r_gnt;
  assign rsp_valid = (r_state == S_RESPOND) ? r_gnt : '0;
  assign rsp_R     = r_rsp_r;
  assign add_reset = (r_state != S_WAIT);
  assign add_P     = r_p;
  assign add_Q     = r_q;
  assign busy      = (r_state != S_IDLE);
  assign ops_count = r_ops;

endmodule

// File: tb/tb_point_add_arbiter.sv
// tb/tb_point_add_arbiter.sv - randomized and directed checks of point_add_arbiter against a transaction model
module tb_point_add_arbiter;
  import point_add_pkg::*;

  logic         clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic [3:0]   req = '0;
  curve_point_t req_P [4];
  curve_point_t req_Q [4];
  logic [3:0]   gnt, rsp_valid;
  curve_point_t rsp_R, add_P, add_Q, add_R;
  logic         add_reset, add_done, busy;
  logic [31:0]  ops_count;

  point_add_arbiter dut (
    .clk(clk), .Reset_n(Reset_n), .req(req), .req_P(req_P), .req_Q(req_Q),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_R(rsp_R), .add_reset(add_reset),
    .add_P(add_P), .add_Q(add_Q), .add_R(add_R), .add_done(add_done),
    .busy(busy), .ops_count(ops_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic curve_point_t pt(input int n);
    curve_point_t p;
    p.x = 16'(n);
    p.y = 16'(3 * n);
    return p;
  endfunction

  function automatic curve_point_t toy_add(input curve_point_t a, input curve_point_t b);
    curve_point_t r;
    r.x = a.x + b.x;
    r.y = a.y + b.y;
    return r;
  endfunction

  function automatic curve_point_t rpt();
    int n;
    n = int'($urandom_range(0, 11));
    return (n < 2) ? inf_point : pt(n);
  endfunction

  // Stand-in adder: Done rises once the latency has elapsed after Reset drops.
  int lat_cfg = 10;
  initial begin
    int cnt, cur_lat;
    cnt = 0;
    cur_lat = 1;
    add_done = 1'b0;
    add_R = inf_point;
    forever begin
      @(negedge clk);
      if (add_reset) begin
        cnt = 0;
        add_done = 1'b0;
        cur_lat = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 6));
      end else begin
        cnt++;
        if (cnt > cur_lat && !add_done) begin
          add_done = 1'b1;
          add_R = toy_add(add_P, add_Q);
        end
      end
    end
  end

  // Transaction model: one job at a time, identified by requester index.
  int           m_job = -1;
  int           m_ptr = 0;
  bit           m_launch = 0, m_wait = 0, m_resp = 0;
  curve_point_t m_p = inf_point, m_q = inf_point, m_res = inf_point;
  logic [31:0]  m_ops = '0;

  task automatic model_step();
    int w;
    int j;
    logic [3:0] elig;
    if (!Reset_n) begin
      m_job = -1; m_ptr = 0; m_ops = '0;
      m_launch = 0; m_wait = 0; m_resp = 0;
      return;
    end
    elig = req;
    if (m_resp) begin
      m_ops = m_ops + 1;
      m_ptr = (m_job + 1) % 4;
      elig[m_job] = 1'b0;
      m_job = -1;
      m_resp = 0;
    end
    if (m_job < 0) begin
      w = -1;
      for (int k = 0; k < 4; k++) begin
        j = (m_ptr + k) % 4;
        if (w < 0 && elig[j]) w = j;
      end
      if (w >= 0) begin
        m_job = w;
        m_p = req_P[w];
        m_q = req_Q[w];
        if (m_p == inf_point || m_q == inf_point) begin
          m_res = (m_p == inf_point) ? m_q : m_p;
          m_resp = 1;
        end else begin
          m_launch = 1;
        end
      end
    end else if (m_launch) begin
      m_launch = 0;
      m_wait = 1;
    end else if (m_wait && add_done) begin
      m_wait = 0;
      m_res = toy_add(m_p, m_q);
      m_resp = 1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge Reset_n);
    model_step();
  end

  initial forever begin
    logic [3:0] eg;
    @(negedge clk);
    eg = 4'b0001;
    eg = (m_job >= 0) ? (eg << m_job) : 4'b0000;
    chk("gnt", gnt, eg);
    chk("rsp_valid", rsp_valid, m_resp ? eg : 4'b0000);
    chk("busy", busy, m_job >= 0);
    chk("add_reset", add_reset, !m_wait);
    chk("ops_count", ops_count, m_ops);
    if (m_launch || m_wait) begin
      chk("add_P", add_P, m_p);
      chk("add_Q", add_Q, m_q);
    end
    if (m_resp || !Reset_n) chk("rsp_R", rsp_R, m_resp ? m_res : inf_point);
  end

  // Requester behaviour applied every cycle by the stimulus process.
  bit         rand_en = 0;
  bit         rereq = 0;
  logic [3:0] pend = '0;
  logic [3:0] active = '0;

  task automatic step();
    @(negedge clk);
    req = req | pend;
    pend = '0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid[i]) begin
        req[i] = 1'b0;
        active[i] = 1'b0;
        if (rereq) pend[i] = 1'b1;
      end else if (rand_en) begin
        if (!active[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            active[i] = 1'b1;
            req_P[i] = rpt();
            req_Q[i] = rpt();
          end
        end else if (gnt[i]) begin
          if ($urandom_range(0, 1) == 0) begin
            req_P[i] = rpt();
            req_Q[i] = rpt();
          end
          if (req[i] && $urandom_range(0, 7) == 0) req[i] = 1'b0;
          else if (!req[i] && $urandom_range(0, 1) == 0) req[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_rsp(input int lim);
    for (int n = 0; n < lim; n++) begin
      if (rsp_valid != 4'b0000) break;
      step();
    end
  endtask

  task automatic drain(input int lim);
    for (int n = 0; n < lim; n++) begin
      if (!busy && active == 4'b0000) break;
      step();
    end
  endtask

  task automatic do_reset();
    req = '0; pend = '0; active = '0;
    Reset_n = 1'b0;
    step();
    step();
    Reset_n = 1'b1;
    step();
  endtask

  initial begin
    int order [5];
    int got;
    int ar_cnt;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      req_P[i] = inf_point;
      req_Q[i] = inf_point;
    end
    step();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_add_reset", add_reset, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ops", ops_count, 32'd0);
    chk("rst_rsp_R", rsp_R, inf_point);
    chk("rst_add_P", add_P, inf_point);
    Reset_n = 1'b1;
    step();

    // Single request through the adder, Done after 10 cycles
    lat_cfg = 10;
    req_P[0] = pt(1); req_Q[0] = pt(2); req = 4'b0001;
    step();
    chk("t1_gnt", gnt, 4'b0001);
    ar_cnt = add_reset ? 1 : 0;
    cyc = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      cyc++;
      if (rsp_valid != 4'b0000) break;
      if (add_reset) ar_cnt++;
    end
    chk("t1_latency", cyc, 12);
    chk("t1_add_reset_cycles", ar_cnt, 1);
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_R", rsp_R, pt(3));
    step();
    chk("t1_ops", ops_count, 32'd1);
    chk("t1_busy", busy, 1'b0);

    // Round robin with all four requesters re-requesting
    do_reset();
    lat_cfg = 0;
    for (int i = 0; i < 4; i++) begin
      req_P[i] = pt(1);
      req_Q[i] = pt(i + 1);
      order[i] = -1;
    end
    order[4] = -1;
    rereq = 1;
    req = 4'b1111;
    got = 0;
    for (int n = 0; n < 400 && got < 5; n++) begin
      step();
      for (int i = 0; i < 4; i++)
        if (rsp_valid[i] && got < 5) begin
          order[got] = i;
          got++;
        end
    end
    rereq = 0;
    req = '0;
    pend = '0;
    for (int k = 0; k < 5; k++) chk("t2_order", order[k], k % 4);
    drain(100);

    // Bypass with one and two infinite operands
    req_P[2] = inf_point; req_Q[2] = pt(5); req = 4'b0100;
    step();
    chk("t3_gnt", gnt, 4'b0100);
    chk("t3_rsp_valid", rsp_valid, 4'b0100);
    chk("t3_rsp_R", rsp_R, pt(5));
    chk("t3_add_reset", add_reset, 1'b1);
    step();
    chk("t3_idle", busy, 1'b0);
    req_P[2] = inf_point; req_Q[2] = inf_point; req = 4'b0100;
    step();
    chk("t3_rsp_valid_inf", rsp_valid, 4'b0100);
    chk("t3_rsp_R_inf", rsp_R, inf_point);
    step();

    // Operand stability: scramble operands and drop req mid-WAIT
    lat_cfg = 8;
    req_P[0] = pt(4); req_Q[0] = pt(6); req = 4'b0001;
    step();
    chk("t4_gnt", gnt, 4'b0001);
    step();
    req_P[0] = pt(9); req_Q[0] = pt(11); req[0] = 1'b0;
    step(); step(); step();
    chk("t4_add_P", add_P, pt(4));
    chk("t4_add_Q", add_Q, pt(6));
    req[0] = 1'b1;
    wait_rsp(40);
    chk("t4_rsp_valid", rsp_valid, 4'b0001);
    chk("t4_rsp_R", rsp_R, pt(10));
    step();

    // Asynchronous reset in WAIT, then re-grant of the held request
    req_P[1] = pt(2); req_Q[1] = pt(7); req = 4'b0010;
    step();
    chk("t5_gnt", gnt, 4'b0010);
    step(); step(); step();
    @(posedge clk);
    #3 Reset_n = 1'b0;
    #1;
    chk("t5_rst_gnt", gnt, 4'b0000);
    chk("t5_rst_add_reset", add_reset, 1'b1);
    chk("t5_rst_rsp_R", rsp_R, inf_point);
    chk("t5_rst_ops", ops_count, 32'd0);
    chk("t5_rst_rsp_valid", rsp_valid, 4'b0000);
    step(); step();
    Reset_n = 1'b1;
    step();
    chk("t5_regnt", gnt, 4'b0010);
    wait_rsp(40);
    chk("t5_rsp_valid", rsp_valid, 4'b0010);
    chk("t5_rsp_R", rsp_R, pt(9));
    step();
    chk("t5_ops", ops_count, 32'd1);

    // Back-to-back grants with no IDLE cycle in between
    lat_cfg = 4;
    req_P[0] = pt(1); req_Q[0] = pt(2);
    req_P[1] = pt(3); req_Q[1] = pt(4);
    req = 4'b0011;
    wait_rsp(40);
    chk("t6_rsp0", rsp_valid, 4'b0001);
    chk("t6_rsp0_R", rsp_R, pt(3));
    step();
    chk("t6_gnt1", gnt, 4'b0010);
    chk("t6_busy", busy, 1'b1);
    chk("t6_launch", add_reset, 1'b1);
    wait_rsp(40);
    chk("t6_rsp1", rsp_valid, 4'b0010);
    chk("t6_rsp1_R", rsp_R, pt(7));
    step();
    chk("t6_ops", ops_count, 32'd3);

    // Randomized traffic, latencies and operand churn
    lat_cfg = 0;
    req = '0;
    drain(50);
    rand_en = 1;
    for (int n = 0; n < 4000; n++) step();
    rand_en = 0;
    drain(500);
    chk("final_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
